// File: rtl/frame_scheduler.sv
// Frame scheduler: walks raymarcher coordinates in raster order and streams
// RGB565 results to a row-major framebuffer, one pixel per accepted done strobe.
module frame_scheduler #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic                               clk_pixel_in,
    input  logic                               rst_in,
    input  logic                               frame_start_in,
    input  logic                               continuous_in,
    input  logic                               pixel_done_in,
    input  logic [7:0]                         red_in,
    input  logic [7:0]                         green_in,
    input  logic [7:0]                         blue_in,
    output logic [$clog2(WIDTH)-1:0]           curr_x,
    output logic [$clog2(HEIGHT)-1:0]          curr_y,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]    fb_addr_out,
    output logic [15:0]                        fb_data_out,
    output logic                               fb_we_out,
    output logic                               busy_out,
    output logic                               frame_done_out
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t          state_q;
    logic [XW-1:0]   curr_x_q;
    logic [YW-1:0]   curr_y_q;
    logic [AW-1:0]   wr_cnt_q;
    logic [AW-1:0]   addr_q;
    logic [15:0]     data_q;
    logic            we_q;
    logic            busy_q;
    logic            done_q;

    logic [XW-1:0]   curr_x_d;
    logic [YW-1:0]   curr_y_d;
    logic [15:0]     pix_d;
    logic            last_d;
    logic            unused_lsbs;

    assign unused_lsbs = ^{red_in[2:0], green_in[1:0], blue_in[2:0]};

    always_comb begin
        curr_x_d = curr_x_q + XW'(1);
        curr_y_d = curr_y_q;
        last_d   = 1'b0;
        pix_d    = {red_in[7:3], green_in[7:2], blue_in[7:3]};
        if (curr_x_q == X_LAST) begin
            curr_x_d = '0;
            curr_y_d = curr_y_q + YW'(1);
            if (curr_y_q == Y_LAST) begin
                curr_y_d = '0;
                last_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            curr_x_q <= '0;
            curr_y_q <= '0;
            wr_cnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start_in) begin
                        state_q  <= PRIME;
                        busy_q   <= 1'b1;
                        wr_cnt_q <= '0;
                    end
                end
                // first done after (re)priming carries a stale result
                PRIME: begin
                    if (pixel_done_in) state_q <= RUN;
                end
                RUN: begin
                    if (pixel_done_in) begin
                        we_q     <= 1'b1;
                        addr_q   <= wr_cnt_q;
                        data_q   <= pix_d;
                        wr_cnt_q <= wr_cnt_q + AW'(1);
                        curr_x_q <= curr_x_d;
                        curr_y_q <= curr_y_d;
                        if (last_d) begin
                            done_q   <= 1'b1;
                            wr_cnt_q <= '0;
                            state_q  <= continuous_in ? PRIME : IDLE;
                            busy_q   <= continuous_in;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign curr_x         = curr_x_q;
    assign curr_y         = curr_y_q;
    assign fb_addr_out    = addr_q;
    assign fb_data_out    = data_q;
    assign fb_we_out      = we_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a 4x3 frame with hand-computed expectations.
module tb_frame_scheduler;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        continuous = 1'b0;
    logic        pixel_done = 1'b0;
    logic [7:0]  red = 8'h00;
    logic [7:0]  green = 8'h00;
    logic [7:0]  blue = 8'h00;
    logic [1:0]  curr_x;
    logic [1:0]  curr_y;
    logic [3:0]  fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic        frame_done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    frame_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_pixel_in   (clk),
        .rst_in         (rst),
        .frame_start_in (frame_start),
        .continuous_in  (continuous),
        .pixel_done_in  (pixel_done),
        .red_in         (red),
        .green_in       (green),
        .blue_in        (blue),
        .curr_x         (curr_x),
        .curr_y         (curr_y),
        .fb_addr_out    (fb_addr),
        .fb_data_out    (fb_data),
        .fb_we_out      (fb_we),
        .busy_out       (busy),
        .frame_done_out (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_colour(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        red = r; green = g; blue = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".x"}, curr_x, 0);
        check_eq({tag, ".y"}, curr_y, 0);
        check_eq({tag, ".addr"}, fb_addr, 0);
        check_eq({tag, ".data"}, fb_data, 0);
        check_eq({tag, ".we"}, fb_we, 0);
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".done"}, frame_done, 0);
    endtask

    // Runs pixels first..last back to back, checking each write and the next coordinates.
    task automatic run_pixels(input int first, input int last, input int unsigned exp_data,
                              input bit cont, input int start_at);
        for (int i = first; i <= last; i++) begin
            pixel_done = 1'b1;
            frame_start = (i == start_at);
            tick();
            check_eq($sformatf("px%0d.we", i), fb_we, 1);
            check_eq($sformatf("px%0d.addr", i), fb_addr, i);
            check_eq($sformatf("px%0d.data", i), fb_data, exp_data);
            check_eq($sformatf("px%0d.done", i), frame_done, (i == W*H-1) ? 1 : 0);
            check_eq($sformatf("px%0d.x", i), curr_x, (i + 1) % W);
            check_eq($sformatf("px%0d.y", i), curr_y, ((i + 1) / W) % H);
            check_eq($sformatf("px%0d.busy", i), busy, (i == W*H-1) ? cont : 1);
        end
        pixel_done = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Frame 1: single-shot, white pixels
        set_colour(8'hFF, 8'hFF, 8'hFF);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("start.busy", busy, 1);
        check_eq("start.we", fb_we, 0);
        pixel_done = 1'b1;
        tick();
        check_eq("stale1.we", fb_we, 0);
        check_eq("stale1.x", curr_x, 0);
        check_eq("stale1.y", curr_y, 0);
        run_pixels(0, W*H-1, 16'hFFFF, 1'b0, -1);
        tick();
        check_eq("f1_end.we", fb_we, 0);
        check_eq("f1_end.done", frame_done, 0);
        check_eq("f1_end.busy", busy, 0);

        // pixel_done in IDLE must not write or move coordinates
        pixel_done = 1'b1;
        tick();
        tick();
        pixel_done = 1'b0;
        check_eq("idle_pd.we", fb_we, 0);
        check_eq("idle_pd.busy", busy, 0);
        check_eq("idle_pd.x", curr_x, 0);
        check_eq("idle_pd.y", curr_y, 0);

        // Frame 2: continuous, RGB565 truncation, frame_start ignored mid-run
        set_colour(8'h84, 8'h42, 8'h21);
        continuous = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pixel_done = 1'b1;
        tick();
        check_eq("stale2.we", fb_we, 0);
        run_pixels(0, W*H-1, 16'h8204, 1'b1, 4);
        continuous = 1'b0;
        pixel_done = 1'b1;
        tick();
        check_eq("reprime.we", fb_we, 0);
        check_eq("reprime.busy", busy, 1);
        check_eq("reprime.x", curr_x, 0);

        // Frame 3: gap cycle holds coordinates, then reset mid-frame after pixel 5
        set_colour(8'h12, 8'hF0, 8'h0F);
        run_pixels(0, 0, 16'h1781, 1'b0, -1);
        tick();
        check_eq("gap.we", fb_we, 0);
        check_eq("gap.x", curr_x, 1);
        check_eq("gap.y", curr_y, 0);
        run_pixels(1, 5, 16'h1781, 1'b0, -1);
        pixel_done = 1'b1;
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        tick();
        check_idle_outputs("rst_held");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("post_rst%0d.we", i), fb_we, 0);
            check_eq($sformatf("post_rst%0d.done", i), frame_done, 0);
        end

        // After reset a fresh PRIME is required before any write
        frame_start = 1'b1;
        pixel_done = 1'b0;
        tick();
        frame_start = 1'b0;
        pixel_done = 1'b1;
        tick();
        check_eq("rst_stale.we", fb_we, 0);
        run_pixels(0, 1, 16'h1781, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
